// File: rtl/sipo_buf_ctrl.sv
// Sequencing controller for the 64 x 32-bit serial-in/parallel-out capture buffer.
// Optional sticky overflow flag is built when SIPO_CTRL_OVF_EN is defined.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | waiting for start
// CLR     | clear address and shift register, reset counts
// SHIFT   | accepting serial bits into the shift register
// WRITE   | store the packed word, advance the address
// FULL    | capture complete, waiting for start or rd_start
// RCLR    | clear address ahead of readout
// READ    | memory read strobe, advance the address
// RVALID  | word presented on pout, waiting for rd_ready
module sipo_buf_ctrl #(
  parameter int WORDS_MAX = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] num_words,
  input  logic       sin_valid,
  output logic       sin_ready,
  input  logic       rd_start,
  output logic       pout_valid,
  input  logic       rd_ready,
  input  logic       abort,
  output logic       addrclr,
  output logic       sftregclr,
  output logic       sften,
  output logic       cnten,
  output logic       mem_wen,
  output logic       mem_ren,
  output logic       full,
  output logic       busy,
  output logic [6:0] wr_count,
  output logic       overflow
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_SHIFT, S_WRITE, S_FULL, S_RCLR, S_READ, S_RVALID
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] num_q, num_d;
  logic [6:0] wr_cnt_q, wr_cnt_d;
  logic [6:0] rd_cnt_q, rd_cnt_d;
  logic       start_acc;
  logic       strobe_en;

  assign start_acc = start & ~abort & ((state_q == S_IDLE) | (state_q == S_FULL));

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    num_d     = num_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (start) state_d = S_CLR;
        S_CLR: begin
          bit_cnt_d = '0;
          wr_cnt_d  = '0;
          state_d   = S_SHIFT;
        end
        S_SHIFT: begin
          if (sin_valid) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd31) state_d = S_WRITE;
          end
        end
        S_WRITE: begin
          wr_cnt_d = wr_cnt_q + 7'd1;
          state_d  = (wr_cnt_d == num_q) ? S_FULL : S_SHIFT;
        end
        S_FULL: begin
          if (start)         state_d = S_CLR;
          else if (rd_start) state_d = S_RCLR;
        end
        S_RCLR: begin
          rd_cnt_d = '0;
          state_d  = S_READ;
        end
        S_READ: state_d = S_RVALID;
        S_RVALID: begin
          if (rd_ready) begin
            rd_cnt_d = rd_cnt_q + 7'd1;
            state_d  = (rd_cnt_d == wr_cnt_q) ? S_FULL : S_READ;
          end
        end
        default: state_d = S_IDLE;
      endcase
      // a count of zero requests the full buffer depth
      if (start_acc) num_d = (num_words == 7'd0) ? 7'(WORDS_MAX) : num_words;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      num_q     <= '0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      num_q     <= num_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
    end
  end

  // abort silences every datapath strobe in the cycle it is seen
  assign strobe_en = ~abort;

  assign addrclr   = strobe_en & ((state_q == S_CLR) | (state_q == S_RCLR));
  assign sftregclr = strobe_en & ((state_q == S_CLR) | (state_q == S_WRITE));
  assign sften     = strobe_en & (state_q == S_SHIFT) & sin_valid;
  assign cnten     = strobe_en & ((state_q == S_WRITE) | (state_q == S_READ));
  assign mem_wen   = strobe_en & (state_q == S_WRITE);
  assign mem_ren   = strobe_en & (state_q == S_READ);

  assign sin_ready  = (state_q == S_SHIFT);
  assign pout_valid = (state_q == S_RVALID);
  assign full       = (state_q == S_FULL) | (state_q == S_RCLR) |
                      (state_q == S_READ) | (state_q == S_RVALID);
  assign busy       = (state_q != S_IDLE) & (state_q != S_FULL);
  assign wr_count   = wr_cnt_q;

`ifdef SIPO_CTRL_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (start_acc) begin
      ovf_d = 1'b0;
    end else if (sin_valid && ((state_q == S_FULL) || (state_q == S_RCLR) ||
                               (state_q == S_READ) || (state_q == S_RVALID))) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_buf_ctrl.sv
// Scoreboard bench for sipo_buf_ctrl with a behavioural model of the SIPO datapath.
// Honours SIPO_CTRL_OVF_EN for the expected overflow behaviour.
module tb_sipo_buf_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, sin_valid, rd_start, rd_ready, abort, sin;
  logic [6:0] num_words;
  logic       sin_ready, pout_valid, addrclr, sftregclr, sften, cnten;
  logic       mem_wen, mem_ren, full, busy, overflow;
  logic [6:0] wr_count;

`ifdef SIPO_CTRL_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  always #5 clk = ~clk;

  sipo_buf_ctrl #(.WORDS_MAX(64)) dut (
    .clk(clk), .reset(reset), .start(start), .num_words(num_words),
    .sin_valid(sin_valid), .sin_ready(sin_ready), .rd_start(rd_start),
    .pout_valid(pout_valid), .rd_ready(rd_ready), .abort(abort),
    .addrclr(addrclr), .sftregclr(sftregclr), .sften(sften), .cnten(cnten),
    .mem_wen(mem_wen), .mem_ren(mem_ren), .full(full), .busy(busy),
    .wr_count(wr_count), .overflow(overflow)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // behavioural datapath: shift register, 64-word memory, wrapping address counter
  logic [31:0] sreg_m = '0;
  logic [31:0] pout_m = '0;
  logic [31:0] mem_m [64];
  logic [5:0]  addr_m = '0;

  always @(posedge clk) begin
    if (sftregclr)  sreg_m <= '0;
    else if (sften) sreg_m <= {sreg_m[30:0], sin};
    if (mem_wen) mem_m[addr_m] <= sreg_m;
    if (mem_ren) pout_m <= mem_m[addr_m];
    if (addrclr)    addr_m <= '0;
    else if (cnten) addr_m <= addr_m + 6'd1;
  end

  // scoreboard
  logic [37:0] exp_wr [$];
  logic [31:0] exp_rd [$];
  int          wen_cyc [$];
  logic [31:0] cap_words [64];
  int          n_wen = 0;
  int          n_rd  = 0;
  logic        mon_on = 1'b0;
  logic        stall_q = 1'b0;
  logic [31:0] stall_pout = '0;

  always @(negedge clk) begin
    if (mon_on) begin
      check("strobe_excl", {mem_wen & mem_ren, sften & sftregclr}, 0);
      if (mem_wen) begin
        n_wen++;
        wen_cyc.push_back(cyc);
        if (exp_wr.size() == 0) check("unexpected_write", 1, 0);
        else begin
          logic [37:0] e;
          e = exp_wr.pop_front();
          check("wr_addr", addr_m, e[37:32]);
          check("wr_data", sreg_m, e[31:0]);
        end
      end
      if (stall_q) begin
        check("pout_valid_hold", pout_valid, 1);
        check("pout_hold", pout_m, stall_pout);
      end
      if (pout_valid && rd_ready) begin
        n_rd++;
        if (exp_rd.size() == 0) check("unexpected_read", 1, 0);
        else check("rd_data", pout_m, exp_rd.pop_front());
      end
      stall_q    = pout_valid & ~rd_ready;
      stall_pout = pout_m;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cap(input logic [6:0] nw, input bit with_rd);
    num_words = nw;
    start     = 1'b1;
    rd_start  = with_rd;
    tick();
    start    = 1'b0;
    rd_start = 1'b0;
    if (with_rd) check("start_wins", {addrclr, sftregclr}, 2'b11);
  endtask

  // mode 0: continuous, 1: valid toggles 0/1, 2: random gaps
  task automatic send_word(input logic [31:0] d, input int mode, input int nbits);
    int  k;
    logic acc;
    for (int i = 31; i > 31 - nbits; i--) begin
      if (mode == 1 || (mode == 2 && $urandom_range(3) == 0)) begin
        sin_valid = 1'b0;
        sin       = 1'($urandom);
        tick();
      end
      sin       = d[i];
      sin_valid = 1'b1;
      k   = 0;
      acc = 1'b0;
      while (!acc && k < 200) begin
        @(negedge clk);
        acc = sin_ready;
        @(posedge clk);
        #1;
        k++;
      end
      if (!acc) check("sin_accept_timeout", 0, 1);
    end
  endtask

  task automatic capture(input int n, input int mode, input bit fixed);
    logic [31:0] d;
    for (int w = 0; w < n; w++) begin
      d = fixed ? cap_words[w] : $urandom;
      cap_words[w] = d;
      exp_wr.push_back({6'(w), d});
      send_word(d, mode, 32);
    end
    sin_valid = 1'b0;
  endtask

  // mode 0: rd_ready high after stalls, 1: random rd_ready
  task automatic readout(input int n, input int mode, input int stall_n);
    int   base, it, stalls, first_pv;
    logic pv;
    for (int i = 0; i < n; i++) exp_rd.push_back(cap_words[i]);
    base = n_rd;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    it = 0; stalls = 0; first_pv = -1;
    while (n_rd < base + n && it < 4000) begin
      if (n_rd == base && stalls < stall_n) rd_ready = 1'b0;
      else if (mode == 0)                   rd_ready = 1'b1;
      else                                  rd_ready = 1'($urandom_range(1));
      @(negedge clk);
      pv = pout_valid;
      if (pv && first_pv < 0) first_pv = it;
      if (pv && !rd_ready) stalls++;
      @(posedge clk);
      #1;
      it++;
    end
    rd_ready = 1'b0;
    check("rd_words", n_rd - base, n);
    check("pv_latency", 64'(first_pv), 2);
    if (mode == 0) check("rd_cycles", it, 2 * n + 1 + stall_n);
    check("rd_back_full", {full, busy, pout_valid}, 3'b100);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, expected finish before 1ms");
    $fatal(1, "timeout");
  end

  initial begin
    int c0, w0, n;
    reset = 1'b1; start = 1'b0; sin_valid = 1'b0; rd_start = 1'b0;
    rd_ready = 1'b0; abort = 1'b0; sin = 1'b0; num_words = '0;
    repeat (3) tick();
    reset  = 1'b0;
    mon_on = 1'b1;

    check("reset_outputs", {sin_ready, pout_valid, addrclr, sftregclr, sften, cnten,
                            mem_wen, mem_ren, full, busy, overflow}, 0);
    check("reset_wr_count", wr_count, 0);

    // two-word continuous capture with exact timing
    c0 = cyc; w0 = n_wen; wen_cyc.delete();
    start_cap(7'd2, 1'b0);
    check("clr_strobes", {addrclr, sftregclr, busy}, 3'b111);
    capture(2, 0, 1'b0);
    check("t2_full_early", full, 0);
    tick();
    check("t2_full", {full, busy, sin_ready}, 3'b100);
    check("t2_wr_count", wr_count, 2);
    check("t2_wen_count", n_wen - w0, 2);
    if (wen_cyc.size() == 2) begin
      check("t2_wen0_cycle", wen_cyc[0] - c0, 34);
      check("t2_wen_gap", wen_cyc[1] - wen_cyc[0], 33);
    end else check("t2_wen_queue", wen_cyc.size(), 2);
    readout(2, 1, 0);

    // recapture from FULL with start and rd_start together, known words
    cap_words[0] = 32'hDEADBEEF;
    cap_words[1] = 32'h12345678;
    start_cap(7'd2, 1'b1);
    capture(2, 2, 1'b1);
    tick();
    check("t4_full", full, 1);
    readout(2, 0, 3);
    readout(2, 0, 0);

    // overflow in FULL
    sin_valid = 1'b1;
    tick();
    sin_valid = 1'b0;
    check("ovf_set", overflow, OVF_EXP);
    repeat (2) tick();
    check("ovf_sticky", overflow, OVF_EXP);

    // abort during WRITE with start in the same cycle
    start_cap(7'd3, 1'b0);
    check("ovf_cleared", overflow, 0);
    capture(1, 0, 1'b0);
    send_word($urandom, 0, 32);
    sin_valid = 1'b0;
    abort = 1'b1;
    start = 1'b1;
    #1;
    check("abort_strobes", {addrclr, sftregclr, sften, cnten, mem_wen, mem_ren}, 0);
    tick();
    abort = 1'b0;
    start = 1'b0;
    check("abort_state", {busy, full, sin_ready, addrclr, sftregclr}, 0);
    check("abort_wr_count", wr_count, 1);
    check("abort_sb_empty", exp_wr.size(), 0);

    // reset mid-SHIFT
    start_cap(7'd3, 1'b0);
    capture(1, 0, 1'b0);
    send_word($urandom, 0, 10);
    check("pre_reset_wr_count", wr_count, 1);
    reset = 1'b1;
    tick();
    check("rst_strobes", {addrclr, sftregclr, sften, cnten, mem_wen, mem_ren, sin_ready}, 0);
    check("rst_wr_count", wr_count, 0);
    tick();
    reset = 1'b0;
    sin_valid = 1'b0;
    check("rst_idle", {busy, full, pout_valid}, 0);

    // full-depth capture with toggling valid
    w0 = n_wen;
    start_cap(7'd0, 1'b0);
    capture(64, 1, 1'b0);
    check("fd_full_early", full, 0);
    tick();
    check("fd_full", full, 1);
    check("fd_wr_count", wr_count, 64);
    check("fd_wen_count", n_wen - w0, 64);
    check("fd_addr_wrap", addr_m, 0);
    readout(64, 1, 0);

    // random lengths and gaps
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(8, 1);
      start_cap(7'(n), 1'b0);
      capture(n, 2, 1'b0);
      tick();
      check("rnd_full", full, 1);
      check("rnd_wr_count", wr_count, n);
      readout(n, 1, 0);
    end

    check("sb_wr_drained", exp_wr.size(), 0);
    check("sb_rd_drained", exp_rd.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sipo_buf_ctrl.md
# sipo_buf_ctrl

Sequencing controller for the 256-byte serial-in/parallel-out capture buffer datapath: 64 words of 32 bits, with a scan shift register feeding a memory through a wrapping 0..63 address counter. It accepts a qualified serial bit stream and packs every 32 bits into one memory word. After a programmed number of words it reports full, then replays the stored words on `pout` under a valid/ready handshake. It drives every datapath control strobe, so the datapath needs no other sequencing logic.

## Interface
Parameters:
- `WORDS_MAX`, 64: buffer depth in words; must match the address counter range (0..63).

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: sole clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high; forces IDLE and clears all counters and flags.
- `start` input 1: begin a capture; sampled only in IDLE or FULL.
- `num_words` input 7: words to capture, sampled when `start` is accepted; 1..64, and 0 means 64.
- `sin_valid` input 1: current datapath `sin` bit is valid; consumed when `sin_ready`=1.
- `sin_ready` output 1: controller accepts a bit this cycle.
- `rd_start` input 1: begin readout; sampled only in FULL.
- `pout_valid` output 1: datapath `pout` holds a stored word.
- `rd_ready` input 1: consumer accepts `pout` when `pout_valid`=1.
- `abort` input 1: return to IDLE from any state; datapath contents are not cleared.
- `addrclr`, `sftregclr`, `sften`, `cnten`, `mem_wen`, `mem_ren` output 1 each: datapath strobes.
- `full` output 1: capture complete; buffer holds `wr_count` words.
- `busy` output 1: state is not IDLE and not FULL.
- `wr_count` output 7: words written in the current or last capture.
- `overflow` output 1: sticky; see Configuration.

## Operation
- **States:** IDLE, CLR, SHIFT, WRITE, FULL, RCLR, READ, RVALID.
- **IDLE:** `start` moves to CLR.
- **CLR (1 cycle):**
  - Asserts `addrclr` and `sftregclr`.
  - Latches `num_words` and zeroes the 5-bit bit counter and `wr_count`.
  - Moves to SHIFT.
- **SHIFT:**
  - `sin_ready`=1, and `sften` = `sin_valid`.
  - Each accepted bit increments the bit counter.
  - The 32nd accepted bit (bit counter 31 → wraps to 0) moves to WRITE.
- **WRITE (1 cycle):**
  - `sin_ready`=0.
  - Asserts `mem_wen`, `cnten` and `sftregclr` together. The memory writes at the pre-increment address.
  - `wr_count`+1.
  - Moves to FULL if the new `wr_count` equals the latched count, otherwise back to SHIFT.
- **FULL:**
  - `full`=1 and `sin_ready`=0.
  - `start` re-captures through CLR. `rd_start` moves to RCLR. If both are asserted, `start` wins.
- **RCLR (1 cycle):** asserts `addrclr`, zeroes the read counter, moves to READ.
- **READ (1 cycle):** asserts `mem_ren` and `cnten`, moves to RVALID.
- **RVALID:**
  - `pout_valid`=1 and holds until `rd_ready`.
  - When `rd_ready` is seen, the read counter +1. Moves to READ, or to FULL after the `wr_count`-th word. `full` stays 1, so readout can repeat.
- **abort:** has priority over every other input. Next state is IDLE, all strobes are 0 in that cycle, and `wr_count` is held.
- **Address wrap:** 64 words end with the counter wrapped to 0. This is harmless because CLR and RCLR always clear it first.
- **Strobe rules:**
  - `mem_wen` and `mem_ren` are never asserted together.
  - `sften` is never asserted in the same cycle as `sftregclr`.

## Timing
- **Reset values:** every output is 0, state is IDLE.
- **Capture:**
  - `start` at cycle t puts CLR in t+1; `sin_ready` is first 1 at t+2.
  - With `sin_valid` held high, each word costs 33 cycles (32 SHIFT + 1 WRITE).
  - `full` rises on the cycle after the last WRITE.
- **Readout:**
  - `rd_start` at cycle t gives RCLR at t+1, READ at t+2, and `pout_valid` at t+3.
  - Memory read latency is 1 cycle, so `pout` is valid in RVALID.
  - With `rd_ready` held high, throughput is 1 word per 2 cycles.
- **Handshake:**
  - The valid signal of a transfer must not depend combinationally on the ready signal.
  - `sin_ready` and `pout_valid` are decoded directly from the state register.
- **Reset mid-operation:** the next cycle is IDLE with all strobes 0; a partial word is discarded.

## Configuration
- **`SIPO_CTRL_OVF_EN` defined:**
  - `overflow` sets when `sin_valid`=1 while the state is FULL, RCLR, READ or RVALID.
  - It stays set until `reset` or an accepted `start`.
- **`SIPO_CTRL_OVF_EN` undefined:** `overflow` is tied to 0, and those bits are silently dropped.

## Test plan
- **Reset:** assert `reset` 2 cycles mid-SHIFT → all strobes 0, `wr_count`=0, and `sin_ready`=0 the next cycle.
- **Two-word capture:** `num_words`=2, 64 bits streamed continuously →
  - exactly 2 `mem_wen` pulses, at addr 0 and 1, 33 cycles apart;
  - `full`=1 and `wr_count`=2.
- **Full-depth gapped capture:** `num_words`=0 with `sin_valid` toggling 1/0 →
  - 64 writes;
  - address wraps to 0;
  - `full` after the 2048th bit.
- **Readout with backpressure:** words 0xDEADBEEF and 0x12345678, `rd_ready` low 3 cycles on the first word →
  - `pout_valid` and `pout` held stable until accepted;
  - words delivered in order;
  - return to FULL.
- **Abort:** `abort` during WRITE, with `start` asserted in the same cycle → IDLE, `mem_wen` not asserted that cycle.
- **Overflow:** with the macro defined, `sin_valid` in FULL → `overflow`=1 until `start`. Without the macro → `overflow` stays 0.
